// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock.
// Digits above 9 are flagged through err with a single-cycle done pulse, and no conversion is run.
//
// state | meaning
// IDLE  | waiting for start; a start with a bad digit completes here as an error
// SHIFT | shifting {bcd_sr, bin_sr} right, adjusting each digit after every shift
module bcd_to_binary_seq #(
  parameter int DIGITS = 9,
  parameter int BIN_W  = 30
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [BCD_W-1:0]   bcd_sr, bcd_nxt, bcd_shift;
  logic [BIN_W-1:0]   bin_sr, bin_nxt, bin_shift, bin_out_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               done_nxt, err_nxt;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // After a right shift, a digit of 8 or more carried a 10 in from the digit above; take back 3.
  function automatic logic [BCD_W-1:0] adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic [3:0]       d;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (d >= 4'd8) d = d - 4'd3;
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  assign bin_shift = {bcd_sr[0], bin_sr[BIN_W-1:1]};
  assign bcd_shift = adjust({1'b0, bcd_sr[BCD_W-1:1]});
  assign busy      = (state == SHIFT);

  always_comb begin
    state_nxt   = state;
    bcd_nxt     = bcd_sr;
    bin_nxt     = bin_sr;
    cnt_nxt     = cnt;
    done_nxt    = 1'b0;
    err_nxt     = err;
    bin_out_nxt = bin_out;
    case (state)
      IDLE: begin
        if (start) begin
          bcd_nxt = bcd_in;
          bin_nxt = '0;
          cnt_nxt = CNT_W'(BIN_W - 1);
          err_nxt = 1'b0;
          if (has_bad_digit(bcd_in)) begin
            done_nxt    = 1'b1;
            err_nxt     = 1'b1;
            bin_out_nxt = '0;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_nxt = bcd_shift;
        bin_nxt = bin_shift;
        if (cnt == '0) begin
          bin_out_nxt = bin_shift;
          done_nxt    = 1'b1;
          err_nxt     = 1'b0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bcd_sr  <= '0;
      bin_sr  <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      state   <= state_nxt;
      bcd_sr  <= bcd_nxt;
      bin_sr  <= bin_nxt;
      cnt     <= cnt_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      bin_out <= bin_out_nxt;
    end
  end

endmodule
